// File: rtl/packet_receiver.sv
// packet_receiver: 8N1 UART receiver that assembles PACKET_SIZE bytes into one
// flat packet vector, first byte in the most significant lane.
// Optional feature: define PACKET_RX_TIMEOUT_EN to enable the inter-byte idle
// timeout (TIMEOUT_CLKS). Without it, timeout is tied low and a partial packet
// waits indefinitely.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line idle or between bytes; waits for a 1->0 edge on rxs
// START | half-bit wait, then confirm the start bit is still low
// DATA  | sample 8 data bits LSB first, one per bit period
// STOP  | sample stop bit; accept byte or flag a framing error
`timescale 1ns/1ps

module packet_receiver #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned PACKET_SIZE  = 16'd9,
  parameter logic [31:0] TIMEOUT_CLKS = 32'd20000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rxd,
  output logic [8*PACKET_SIZE-1:0] packet,
  output logic                     valid,
  output logic                     busy,
  output logic                     frame_err,
  output logic                     timeout
);

  localparam int unsigned PW = 8 * PACKET_SIZE;
  localparam int          CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] TMR_ONE   = CW'(1);
  localparam logic [15:0]   PKT_LAST  = 16'(PACKET_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  logic            rx_meta;
  logic            rxs;
  logic            rxs_d;
  logic [CW-1:0]   bit_tmr;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;
  logic [15:0]     byte_cnt;
  logic [PW-1:0]   asm_reg;
  logic [PW-1:0]   asm_next;

`ifdef PACKET_RX_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = TIMEOUT_CLKS - 32'd1;
  logic [31:0] idle_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CLKS;
  assign timeout = 1'b0;
`endif

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  // All reset to the idle-high line level so reset never looks like a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  // Assembly register with the freshly received byte shifted into the low lane;
  // works for PACKET_SIZE == 1 as well, where the shift discards everything.
  always_comb begin
    asm_next      = asm_reg << 8;
    asm_next[7:0] = shift_reg;
  end

  // Byte FSM and packet assembly with registered outputs. busy rises only once
  // the start bit is confirmed at mid-bit, so a rejected start glitch leaves
  // every output untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_tmr   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      byte_cnt  <= '0;
      asm_reg   <= '0;
      packet    <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
`ifdef PACKET_RX_TIMEOUT_EN
      idle_cnt  <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef PACKET_RX_TIMEOUT_EN
      timeout   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rxs_d && !rxs) begin
            state   <= START;
            bit_tmr <= HALF_LOAD;
            bit_idx <= '0;
`ifdef PACKET_RX_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
`ifdef PACKET_RX_TIMEOUT_EN
          else if (byte_cnt != 16'd0) begin
            if (idle_cnt == TO_LAST) begin
              timeout  <= 1'b1;
              byte_cnt <= '0;
              asm_reg  <= '0;
              busy     <= 1'b0;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 32'd1;
            end
          end
`endif
        end

        START: begin
          if (bit_tmr != '0) begin
            bit_tmr <= bit_tmr - TMR_ONE;
          end else if (!rxs) begin
            state   <= DATA;
            bit_tmr <= FULL_LOAD;
            busy    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        DATA: begin
          if (bit_tmr != '0) begin
            bit_tmr <= bit_tmr - TMR_ONE;
          end else begin
            shift_reg <= {rxs, shift_reg[7:1]};
            bit_tmr   <= FULL_LOAD;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        STOP: begin
          if (bit_tmr != '0) begin
            bit_tmr <= bit_tmr - TMR_ONE;
          end else begin
            state <= IDLE;
            if (rxs) begin
              if (byte_cnt == PKT_LAST) begin
                packet   <= asm_next;
                valid    <= 1'b1;
                byte_cnt <= '0;
                asm_reg  <= '0;
                busy     <= 1'b0;
              end else begin
                asm_reg  <= asm_next;
                byte_cnt <= byte_cnt + 16'd1;
              end
            end else begin
              // Bad stop bit: drop the partial packet. Re-arming needs a fresh
              // 1->0 edge, so a line held low cannot restart reception.
              frame_err <= 1'b1;
              byte_cnt  <= '0;
              asm_reg   <= '0;
              busy      <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
